// File: rtl/fp_cmp_arbiter.sv
// fp_cmp_arbiter: round-robin shared FEQ/FLT/FLE comparator for two requesters with registered valid/ready response.
//
// Ports: clk, rst (sync, active-high); per requester N in {0,1}: reqN_valid, reqN_ready, reqN_op
// (00 FEQ, 01 FLT, 10 FLE, 11 reserved), reqN_a, reqN_b (binary32); response: rsp_valid, rsp_ready,
// rsp_id, rsp_result, rsp_nv.
// Macro FP_CMP_ARB_NV_FLAG_EN: when defined rsp_nv follows RISC-V invalid rules, otherwise tied to 0.

module fp_feq (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        eq_o
);
  logic nan_a, nan_b;
  assign nan_a = (a_i[30:23] == 8'hff) && (a_i[22:0] != 23'd0);
  assign nan_b = (b_i[30:23] == 8'hff) && (b_i[22:0] != 23'd0);
  // +0 and -0 are equal: both magnitudes zero
  assign eq_o  = ~nan_a & ~nan_b & ((a_i == b_i) | ~|(a_i[30:0] | b_i[30:0]));
endmodule

module fp_fle (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        le_o
);
  logic nan_a, nan_b, both_zero, mag_le;
  assign nan_a     = (a_i[30:23] == 8'hff) && (a_i[22:0] != 23'd0);
  assign nan_b     = (b_i[30:23] == 8'hff) && (b_i[22:0] != 23'd0);
  assign both_zero = ~|(a_i[30:0] | b_i[30:0]);
  // sign-magnitude ordering: for negatives the larger magnitude is the smaller value
  assign mag_le    = (a_i[31] != b_i[31]) ? a_i[31] :
                     a_i[31] ? (a_i[30:0] >= b_i[30:0]) : (a_i[30:0] <= b_i[30:0]);
  assign le_o      = ~nan_a & ~nan_b & (both_zero | mag_le);
endmodule

module fp_cmp_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic        rsp_result,
  output logic        rsp_nv
);
  typedef enum logic [1:0] {IDLE, CAPTURE, RESP} state_t;
  state_t      state_q, state_d;
  logic        rr_q, id_q, grant, accept, eq, le, res_d, nv_d;
  logic        rsp_id_q, rsp_result_q, rsp_nv_q;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;

  assign grant  = (req0_valid & req1_valid) ? rr_q : req1_valid;
  assign accept = (state_q == IDLE) & (req0_valid | req1_valid);

  assign req0_ready = ~rst & (state_q == IDLE) & ~grant;
  assign req1_ready = ~rst & (state_q == IDLE) & grant;
  assign rsp_valid  = state_q == RESP;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_nv     = rsp_nv_q;

  fp_feq u_feq (.a_i(a_q), .b_i(b_q), .eq_o(eq));
  fp_fle u_fle (.a_i(a_q), .b_i(b_q), .le_o(le));

  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE) ? (accept ? CAPTURE : IDLE) :
              (state_q == CAPTURE) ? RESP : (rsp_ready ? IDLE : RESP);
    res_d   = (op_q == 2'b00) ? eq : (op_q == 2'b01) ? (le & ~eq) : (op_q == 2'b10) ? le : 1'b0;
  end

`ifdef FP_CMP_ARB_NV_FLAG_EN
  logic nan_a, nan_b, snan_a, snan_b;
  assign nan_a  = (a_q[30:23] == 8'hff) && (a_q[22:0] != 23'd0);
  assign nan_b  = (b_q[30:23] == 8'hff) && (b_q[22:0] != 23'd0);
  assign snan_a = nan_a & ~a_q[22];
  assign snan_b = nan_b & ~b_q[22];
  // FEQ is quiet: only signaling NaNs raise invalid; ordered compares raise on any NaN
  assign nv_d   = (op_q == 2'b00) ? (snan_a | snan_b) :
                  (op_q == 2'b11) ? 1'b0 : (nan_a | nan_b);
`else
  assign nv_d   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= 1'b0;
      id_q         <= 1'b0;
      op_q         <= 2'b00;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 1'b0;
      rsp_nv_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q <= grant;
        op_q <= grant ? req1_op : req0_op;
        a_q  <= grant ? req1_a : req0_a;
        b_q  <= grant ? req1_b : req0_b;
        rr_q <= ~grant;
      end
      if (state_q == CAPTURE) begin
        rsp_id_q     <= id_q;
        rsp_result_q <= res_d;
        rsp_nv_q     <= nv_d;
      end
    end
  end
endmodule

// File: doc/fp_cmp_arbiter.md
# fp_cmp_arbiter

Shared comparison unit for the IEEE-754 single-precision FPU. It arbitrates FEQ/FLT/FLE requests from two requesters (for example the scalar ALU path and the min/max/classify path) onto one registered comparator datapath built from the existing `fp_feq` and `fp_fle` blocks. Grants alternate round-robin, operands are captured, the result is registered, and it is returned with a valid/ready response tagged with the requester ID.

## Interface
- No parameters; data width fixed at 32 bits (binary32).
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` input 1: requester 0 has a request.
- `req0_ready` output 1: requester 0 request accepted this cycle when high with `req0_valid`.
- `req0_op` input 2: 00 FEQ, 01 FLT, 10 FLE, 11 reserved.
- `req0_a`, `req0_b` input 32: operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same for requester 1.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer accepts result.
- `rsp_id` output 1: requester that owns the result.
- `rsp_result` output 1: comparison outcome.
- `rsp_nv` output 1: invalid-operation flag (see Configuration).

## Operation
- FSM states:
  - IDLE → CAPTURE on any accepted request.
  - CAPTURE → RESP unconditionally after one cycle.
  - RESP → IDLE when `rsp_valid && rsp_ready`.
- Arbitration runs in IDLE only.
  - If only one `reqN_valid` is high, that requester is granted.
  - If both are high, the requester selected by `rr_ptr` is granted.
  - `reqN_ready = (state==IDLE) && grant==N`. Grant is combinational from the valids and `rr_ptr`.
  - On acceptance: latch op, a, b, and id; set `rr_ptr` to the non-granted requester.
- In CAPTURE, the latched operands drive `fp_feq` and `fp_fle`.
  - FEQ: result = eq.
  - FLE: result = le.
  - FLT: result = le & ~eq.
  - Reserved op: result 0, nv 0.
  - Result and nv are registered into the response registers at the end of CAPTURE.
- Any NaN operand gives result 0 for all ops. +0 and −0 compare equal, so FLE(+0,−0)=1 and FLT(+0,−0)=0.
- NaN detection: exponent 8'hFF and fraction ≠ 0. A NaN is signaling when fraction bit 22 is 0.
- In RESP: `rsp_valid`=1 and `rsp_id`, `rsp_result`, `rsp_nv` are held stable until the handshake. Both `reqN_ready` are 0.
- A request is never dropped once accepted. Requesters must hold valid and payload until ready.

## Timing
- Reset values:
  - `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_nv` = 0.
  - `req0_ready`, `req1_ready` = 0 during reset.
  - state = IDLE, `rr_ptr` = 0 (requester 0 wins the first tie).
- Latency: request accepted at edge N; `rsp_valid` is high from cycle N+2.
- Response handshake at edge M: state returns to IDLE, and the next request can be accepted at edge M+1.
  - Minimum initiation interval is 3 cycles.
- `rsp_ready` held high in RESP ends the response after exactly one cycle.
- Backpressure: `rsp_valid` and all payload are held indefinitely while `rsp_ready`=0.
- Reset asserted in any state aborts the in-flight operation with no response. All outputs return to reset values the following cycle.

## Configuration
- Macro: `FP_CMP_ARB_NV_FLAG_EN`.
- Defined: `rsp_nv` follows RISC-V rules.
  - FEQ: nv=1 only if either operand is a signaling NaN.
  - FLT/FLE: nv=1 if either operand is any NaN.
- Not defined: the NaN-classification logic is omitted and `rsp_nv` is tied to 0. Result behaviour is unchanged.

## Test plan
- Reset and idle: hold `rst` high 2 cycles with both valids high → no ready, `rsp_valid`=0. First cycle after release: `req0_ready`=1 (`rr_ptr`=0).
- Single FLT from req1 (a=0x3F800000, b=0x40000000) accepted at edge N → `rsp_valid` at N+2 with `rsp_id`=1, `rsp_result`=1, `rsp_nv`=0.
- Both requesters valid continuously with FEQ(0x00000000, 0x80000000) → grants alternate 0,1,0,1; every result=1; `rsp_id` alternates starting at 0.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in RESP → outputs stable, both readies 0. Raise `rsp_ready` → one-cycle handshake, next request accepted one cycle later.
- NaN handling:
  - FEQ(0x7FC00000, 0x7FC00000) → result 0, nv 0.
  - FEQ(0x7F800001, 0x3F800000) → result 0, nv 1 with the macro, 0 without.
  - FLE(0x7FC00000, 0x7F800000) → result 0, nv 1 with the macro.
- Infinities and reset abort: FLE(0xFF800000, 0x7F800000) → result 1. Then assert `rst` during CAPTURE → no response, `rsp_valid` stays 0, `rr_ptr` back to 0.
